hms_clock_core: RTL and testbench



---
 rtl/hms_clock_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_hms_clock_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_clock_core.sv
// ---------------------------------------------------------------------------
// hms_clock_core
//
// Hour:minute:second timekeeping core for the board-level digital clock.
// Everything runs from the single clock `clk`; the second tick and button
// sampling are clock enables, never derived clocks.
//
// Contents:
//   - second-tick generator (TICK_DIV clk cycles per tick)
//   - conditioning for three active-low push buttons (2-flop sync, sampled
//     every DB_DIV cycles, one-cycle press event on a 1 -> 0 sample change)
//   - mode / position state machine (CLOCK, SETUP, optional ALARM)
//   - cascaded sec/min/hour counters with wrap at 59/59/H_MAX
//
// Optional feature macro: ALARM_EN
//   defined   -> adds ALARM mode, alarm registers, armed flag and o_alarm
//   undefined -> two modes only, o_mode[1] and o_alarm are always 0
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_sw0        mode button, active-low, asynchronous to clk
//   i_sw1        position button, active-low
//   i_sw2        increment button, active-low
//   o_sec        seconds 0..59
//   o_min        minutes 0..59
//   o_hour       hours 0..H_MAX
//   o_mode       0=CLOCK, 1=SETUP, 2=ALARM
//   o_position   0=SEC, 1=MIN, 2=HOUR
//   o_sec_tick   one-cycle pulse per second tick
//   o_day_pulse  one-cycle pulse, high in the cycle the time shows 0:00:00
//                after an H_MAX:59:59 rollover
//   o_alarm      alarm active
// ---------------------------------------------------------------------------
module hms_clock_core #(
  parameter int TICK_DIV = 50000000,
  parameter int DB_DIV   = 500000,
  parameter int H_MAX    = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_tick,
  output logic       o_day_pulse,
  output logic       o_alarm
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_DIV - 1);
  localparam logic [4:0]    HOUR_LAST = 5'(H_MAX);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  function automatic logic [5:0] inc_sixty(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v == HOUR_LAST) ? 5'd0 : v + 5'd1;
  endfunction

  // Button vector ordering: bit 0 = mode, bit 1 = position, bit 2 = increment
  logic [2:0]    btn;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    samp_q, samp_d;
  logic [DW-1:0] smp_cnt_q, smp_cnt_d;
  logic          smp_en;
  logic [2:0]    evt;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          day_q, day_d;
  mode_e         mode_q, mode_d;
  pos_e          pos_q, pos_d;

`ifdef ALARM_EN
  logic [5:0]    al_min_q, al_min_d;
  logic [4:0]    al_hour_q, al_hour_d;
  logic          armed_q, armed_d;
  logic          alarm_q, alarm_d;
`endif

  assign btn = {i_sw2, i_sw1, i_sw0};

  // Button conditioning. A press is reported only on the sample-enable cycle
  // whose fresh sample is 0 while the stored sample is still 1, so a held
  // button produces exactly one event and release produces none.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    smp_en    = (smp_cnt_q == DB_LAST);
    smp_cnt_d = smp_en ? '0 : smp_cnt_q + DW'(1);
    samp_d    = smp_en ? sync2_q : samp_q;
    evt       = {3{smp_en}} & samp_q & ~sync2_q;
  end

  // Second tick generator. Held at zero outside CLOCK so the first tick after
  // returning to CLOCK comes a full TICK_DIV period later.
  always_comb begin
    tick       = (mode_q == MODE_CLOCK) && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = ((mode_q != MODE_CLOCK) || tick) ? '0 : tick_cnt_q + TW'(1);
  end

  // Time counters and mode/position FSM. The tick cascade is evaluated first
  // so a tick coinciding with a mode-button press still lands; a mode press
  // then suppresses any position/increment event in the same cycle.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    day_d  = 1'b0;
    mode_d = mode_q;
    pos_d  = pos_q;
`ifdef ALARM_EN
    al_min_d  = al_min_q;
    al_hour_d = al_hour_q;
    armed_d   = armed_q;
    alarm_d   = alarm_q;
`endif

    if (tick) begin
      sec_d = inc_sixty(sec_q);
      if (sec_q == 6'd59) begin
        min_d = inc_sixty(min_q);
        if (min_q == 6'd59) begin
          hour_d = inc_hour(hour_q);
          day_d  = (hour_q == HOUR_LAST);
        end
      end
    end

    if (evt[0]) begin
      case (mode_q)
        MODE_CLOCK: begin
          mode_d = MODE_SETUP;
          pos_d  = POS_SEC;
        end
`ifdef ALARM_EN
        MODE_SETUP: begin
          mode_d = MODE_ALARM;
          pos_d  = POS_MIN;
        end
`endif
        default: mode_d = MODE_CLOCK;
      endcase
    end else if (mode_q == MODE_SETUP) begin
      // Increment uses the position before any same-cycle position advance
      if (evt[2]) begin
        case (pos_q)
          POS_SEC: sec_d  = inc_sixty(sec_q);
          POS_MIN: min_d  = inc_sixty(min_q);
          default: hour_d = inc_hour(hour_q);
        endcase
      end
      if (evt[1]) begin
        case (pos_q)
          POS_SEC: pos_d = POS_MIN;
          POS_MIN: pos_d = POS_HOUR;
          default: pos_d = POS_SEC;
        endcase
      end
    end
`ifdef ALARM_EN
    else if (mode_q == MODE_ALARM) begin
      if (evt[2]) begin
        if (pos_q == POS_HOUR) al_hour_d = inc_hour(al_hour_q);
        else                   al_min_d  = inc_sixty(al_min_q);
        armed_d = 1'b1;
      end
      if (evt[1]) begin
        pos_d = (pos_q == POS_HOUR) ? POS_MIN : POS_HOUR;
      end
    end

    // The alarm fires only on the tick that moves the time onto al:00, so
    // clearing it with a button does not let it re-trigger within the minute.
    if (|evt) begin
      alarm_d = 1'b0;
    end else if (tick && armed_q && (sec_d == 6'd0) &&
                 (min_d == al_min_q) && (hour_d == al_hour_q)) begin
      alarm_d = 1'b1;
    end else if (min_d != al_min_q) begin
      alarm_d = 1'b0;
    end
`endif
  end

  // State register; all state clears immediately on reset, button history
  // resets to the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      samp_q     <= 3'b111;
      smp_cnt_q  <= '0;
      tick_cnt_q <= '0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      day_q      <= 1'b0;
      mode_q     <= MODE_CLOCK;
      pos_q      <= POS_SEC;
`ifdef ALARM_EN
      al_min_q   <= 6'd0;
      al_hour_q  <= 5'd0;
      armed_q    <= 1'b0;
      alarm_q    <= 1'b0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      samp_q     <= samp_d;
      smp_cnt_q  <= smp_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      mode_q     <= mode_d;
      pos_q      <= pos_d;
`ifdef ALARM_EN
      al_min_q   <= al_min_d;
      al_hour_q  <= al_hour_d;
      armed_q    <= armed_d;
      alarm_q    <= alarm_d;
`endif
    end
  end

  // Output mapping; ALARM mode shows the alarm setting with seconds at 0.
  always_comb begin
    o_mode      = mode_q;
    o_position  = pos_q;
    o_sec_tick  = tick;
    o_day_pulse = day_q;
`ifdef ALARM_EN
    if (mode_q == MODE_ALARM) begin
      o_sec  = 6'd0;
      o_min  = al_min_q;
      o_hour = al_hour_q;
    end else begin
      o_sec  = sec_q;
      o_min  = min_q;
      o_hour = hour_q;
    end
    o_alarm = alarm_q;
`else
    o_sec   = sec_q;
    o_min   = min_q;
    o_hour  = hour_q;
    o_alarm = 1'b0;
`endif
  end

endmodule

// File: tb/tb_hms_clock_core.sv
// ---------------------------------------------------------------------------
// tb_hms_clock_core
//
// Directed testbench for hms_clock_core with TICK_DIV=4, DB_DIV=2, H_MAX=23.
// Expected values are hand-computed from the intended clock behaviour.
// ---------------------------------------------------------------------------
module tb_hms_clock_core;

  logic       clk;
  logic       rst_n;
  logic       i_sw0;
  logic       i_sw1;
  logic       i_sw2;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode;
  logic [1:0] o_position;
  logic       o_sec_tick;
  logic       o_day_pulse;
  logic       o_alarm;

  int checkCount = 0;
  int errorCount = 0;
  int tickCount;
  int expPos;
  logic seen;

  hms_clock_core #(
    .TICK_DIV(4),
    .DB_DIV  (2),
    .H_MAX   (23)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sw0      (i_sw0),
    .i_sw1      (i_sw1),
    .i_sw2      (i_sw2),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hour     (o_hour),
    .o_mode     (o_mode),
    .o_position (o_position),
    .o_sec_tick (o_sec_tick),
    .o_day_pulse(o_day_pulse),
    .o_alarm    (o_alarm)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence stalls
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One press of button btn: held low for lowCycles, then released long
  // enough for the sampled history to return high.
  task automatic applyStimulus(input int btn, input int lowCycles);
    case (btn)
      1:       i_sw1 = 1'b0;
      2:       i_sw2 = 1'b0;
      default: i_sw0 = 1'b0;
    endcase
    repeat (lowCycles) @(negedge clk);
    i_sw0 = 1'b1;
    i_sw1 = 1'b1;
    i_sw2 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pressN(input int btn, input int n);
    for (int k = 0; k < n; k++) applyStimulus(btn, 5);
  endtask

  // Presses the mode button and returns on the first negedge showing the new
  // mode, with the button released; that negedge is cycle 0 of the new mode.
  task automatic pressMode();
    logic [1:0] oldMode;
    oldMode = o_mode;
    seen = 1'b0;
    i_sw0 = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_mode !== oldMode) seen = 1'b1;
    end
    i_sw0 = 1'b1;
    checkOutput("modeChange", seen, 1'b1);
  endtask

  task automatic goClock();
    for (int k = 0; k < 3 && o_mode != 2'd0; k++) begin
      pressMode();
      if (o_mode != 2'd0) repeat (6) @(negedge clk);
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    i_sw0 = 1'b1;
    i_sw1 = 1'b1;
    i_sw2 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
`ifdef ALARM_EN
    expPos = 1;
`else
    expPos = 2;
`endif

    // --- Reset state and free-running count ---
    resetDut();
    checkOutput("rstSec", o_sec, 0);
    checkOutput("rstMode", o_mode, 0);
    checkOutput("rstPos", o_position, 0);
    checkOutput("rstTick", o_sec_tick, 0);
    checkOutput("rstDay", o_day_pulse, 0);
    checkOutput("rstAlarm", o_alarm, 0);
    rst_n = 1'b1;
    tickCount = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (o_sec_tick === 1'b1) tickCount++;
    end
    checkOutput("run16Sec", o_sec, 4);
    checkOutput("run16Ticks", tickCount, 4);
    checkOutput("run16Min", o_min, 0);

    // --- SETUP increments; the mode press lands on cycle 3 with a tick ---
    resetDut();
    rst_n = 1'b1;
    pressMode();
    checkOutput("setupMode", o_mode, 1);
    checkOutput("tickWithMode", o_sec, 1);
    repeat (6) @(negedge clk);
    applyStimulus(2, 50);
    checkOutput("heldIncOnce", o_sec, 2);
    pressN(2, 57);
    checkOutput("sec59", o_sec, 59);
    pressN(2, 1);
    checkOutput("secWrap", o_sec, 0);
    checkOutput("secWrapNoCarry", o_min, 0);
    pressN(1, 1);
    checkOutput("posMin", o_position, 1);
    pressN(1, 1);
    checkOutput("posHour", o_position, 2);
    pressN(2, 25);
    checkOutput("hourWrap", o_hour, 1);
    checkOutput("hourPos", o_position, 2);
    goClock();
    checkOutput("backClock", o_mode, 0);
    pressN(1, 1);
    checkOutput("sw1IgnoredPos", o_position, expPos);
    checkOutput("sw1IgnoredMode", o_mode, 0);
    pressN(2, 1);
    checkOutput("sw2IgnoredHour", o_hour, 1);
    checkOutput("sw2IgnoredMin", o_min, 0);

    // --- Day rollover from 23:59:58 ---
    resetDut();
    rst_n = 1'b1;
    pressMode();
    repeat (6) @(negedge clk);
    pressN(2, 57);
    pressN(1, 1);
    pressN(2, 59);
    pressN(1, 1);
    pressN(2, 23);
    checkOutput("preHour", o_hour, 23);
    checkOutput("preMin", o_min, 59);
    checkOutput("preSec", o_sec, 58);
    goClock();
    repeat (3) @(negedge clk);
    checkOutput("firstTick", o_sec_tick, 1);
    checkOutput("firstTickSec", o_sec, 58);
    @(negedge clk);
    checkOutput("sec59Run", o_sec, 59);
    checkOutput("tickLow", o_sec_tick, 0);
    repeat (3) @(negedge clk);
    checkOutput("secondTick", o_sec_tick, 1);
    @(negedge clk);
    checkOutput("rollSec", o_sec, 0);
    checkOutput("rollMin", o_min, 0);
    checkOutput("rollHour", o_hour, 0);
    checkOutput("dayPulseHigh", o_day_pulse, 1);
    checkOutput("unarmedNoAlarm", o_alarm, 0);
    @(negedge clk);
    checkOutput("dayPulseLow", o_day_pulse, 0);

    // --- Asynchronous reset in SETUP at 10:20:30 ---
    resetDut();
    rst_n = 1'b1;
    pressMode();
    repeat (6) @(negedge clk);
    pressN(2, 29);
    pressN(1, 1);
    pressN(2, 20);
    pressN(1, 1);
    pressN(2, 10);
    checkOutput("setHour", o_hour, 10);
    checkOutput("setMin", o_min, 20);
    checkOutput("setSec", o_sec, 30);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncSec", o_sec, 0);
    checkOutput("asyncMin", o_min, 0);
    checkOutput("asyncHour", o_hour, 0);
    checkOutput("asyncMode", o_mode, 0);
    checkOutput("asyncPos", o_position, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resumeTick", o_sec_tick, 1);
    checkOutput("resumeSec0", o_sec, 0);
    @(negedge clk);
    checkOutput("resumeSec1", o_sec, 1);

`ifdef ALARM_EN
    // --- Alarm at 0:01 ---
    resetDut();
    rst_n = 1'b1;
    pressMode();
    repeat (6) @(negedge clk);
    pressMode();
    checkOutput("alarmMode", o_mode, 2);
    checkOutput("alarmPos", o_position, 1);
    checkOutput("alarmSecShown", o_sec, 0);
    repeat (6) @(negedge clk);
    pressN(2, 1);
    checkOutput("alarmMinSet", o_min, 1);
    pressMode();
    checkOutput("alarmBackClock", o_mode, 0);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (o_min === 6'd1) seen = 1'b1;
    end
    checkOutput("reachMin1", seen, 1'b1);
    checkOutput("alarmFired", o_alarm, 1);
    checkOutput("alarmFiredSec", o_sec, 0);
    pressN(2, 1);
    checkOutput("alarmCleared", o_alarm, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
